// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver, oversampled with a shared baud tick.
//
// The receiver waits for a high-to-low edge on the synchronised line. It
// re-checks the start bit at mid-bit, then samples every data bit and the
// stop bit one full bit period apart, LSB first.
//
// Parameters
//   Bits     data bits per frame (5..8)
//   SB_TICK  oversample ticks spent in the stop bit (16 = one stop bit)
//   OVS      oversample ticks per bit (even; OVS/2 is mid-bit)
//
// Ports
//   i_Clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_bd          baud oversample tick, 1-clock pulse at OVS x bit rate
//   i_Rx_Serial   asynchronous serial line, idles high
//   o_Rx_Byte     last correctly received byte, zero-extended to 8 bits
//   o_Rx_Done     1-clock pulse when o_Rx_Byte has been updated
//   o_Frame_Err   1-clock pulse when the stop bit was sampled low
//   o_Parity_Err  1-clock pulse on even-parity mismatch (parity build only)
//   o_Rx_Active   high from start-bit detect until frame end
//
// Optional feature
//   UART_RX_PARITY_EN : defining this macro inserts an even-parity bit
//   between the data bits and the stop bit, and adds o_Parity_Err.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned Bits    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned OVS     = 16
) (
    input  logic       i_Clock,
    input  logic       i_reset,
    input  logic       i_bd,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Done,
    output logic       o_Frame_Err,
`ifdef UART_RX_PARITY_EN
    output logic       o_Parity_Err,
`endif
    output logic       o_Rx_Active
);

    // Tick counter must reach the larger of the bit and stop-bit lengths.
    localparam int unsigned TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int unsigned BW   = $clog2(Bits + 1);

    localparam logic [TW-1:0] START_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] DATA_LAST  = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(Bits - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick;
    logic [BW-1:0]   bit_cnt;
    logic [Bits-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    logic rx_meta;
    logic rx_s;
    logic rx_prev;
    logic fall_edge;

    // Two-flop synchroniser plus the previous-sample flop for edge detect.
    // All preset high so a reset never looks like a start edge.
    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Only a high-to-low transition arms the receiver; a stuck-low line does not.
    assign fall_edge = rx_prev & ~rx_s;

    // Frame sequencer with registered outputs; strobes default low every clock.
    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
            o_Rx_Byte    <= 8'h00;
            o_Rx_Done    <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Rx_Active  <= 1'b0;
        end else begin
            o_Rx_Done    <= 1'b0;
            o_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    if (fall_edge) begin
                        state       <= S_START;
                        o_Rx_Active <= 1'b1;
                    end
                end

                // Re-check the line at mid start bit to reject short glitches.
                S_START: begin
                    if (i_bd) begin
                        if (tick == START_LAST) begin
                            tick <= '0;
                            if (!rx_s) begin
                                state <= S_DATA;
                            end else begin
                                state       <= S_IDLE;
                                o_Rx_Active <= 1'b0;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end

                // One full bit period after the previous mid-bit sample.
                S_DATA: begin
                    if (i_bd) begin
                        if (tick == DATA_LAST) begin
                            tick    <= '0;
                            shreg   <= {rx_s, shreg[Bits-1:1]};
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (i_bd) begin
                        if (tick == DATA_LAST) begin
                            tick    <= '0;
                            par_bit <= rx_s;
                            state   <= S_STOP;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
`endif

                // Framing error wins over a parity mismatch.
                S_STOP: begin
                    if (i_bd) begin
                        if (tick == STOP_LAST) begin
                            tick        <= '0;
                            state       <= S_IDLE;
                            o_Rx_Active <= 1'b0;
                            if (!rx_s) begin
                                o_Frame_Err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if ((^shreg) ^ par_bit) begin
                                o_Parity_Err <= 1'b1;
`endif
                            end else begin
                                o_Rx_Byte <= 8'(shreg);
                                o_Rx_Done <= 1'b1;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end

                // Unused encodings fall back to idle.
                default: begin
                    state       <= S_IDLE;
                    tick        <= '0;
                    bit_cnt     <= '0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed frames against a frame-level expectation queue.
// Each sent frame pushes the event it must produce (done/frame/parity error
// plus byte); a monitor pops one event per strobe and checks the held byte
// every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int BIT_CLKS = 64;   // 16 ticks x 4 clocks per tick

    localparam int K_DONE = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       bd;
    logic       line;
    logic [7:0] rx_byte;
    logic       done;
    logic       ferr;
    logic       perr;
    logic       active;

    int         checks;
    int         errors;
    int         n_done;
    logic [7:0] last_byte;
    ev_t        exp_q[$];

    uart_rx dut (
        .i_Clock     (clk),
        .i_reset     (rst),
        .i_bd        (bd),
        .i_Rx_Serial (line),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Done   (done),
        .o_Frame_Err (ferr),
`ifdef UART_RX_PARITY_EN
        .o_Parity_Err(perr),
`endif
        .o_Rx_Active (active)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one clock high out of every four.
    initial begin
        bd = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bd = 1'b1;
            @(negedge clk);
            bd = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of strobes and held byte against the event queue.
    task automatic monitor();
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("strobes_exclusive", 32'(int'(done) + int'(ferr) + int'(perr) <= 1), 32'd1);
                if (done || ferr || perr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: done=%0b ferr=%0b perr=%0b, expected none at %0t",
                                 done, ferr, perr, $time);
                    end else begin
                        ev = exp_q.pop_front();
                        check("strobe_kind", 32'(done ? K_DONE : (ferr ? K_FERR : K_PERR)), 32'(ev.kind));
                        if (ev.kind == K_DONE) begin
                            last_byte = ev.data;
                            n_done++;
                        end
                    end
                    check("active_low_at_strobe", 32'(active), 32'd0);
                end
                check("held_byte", 32'(rx_byte), 32'(last_byte));
            end
        end
    endtask

    task automatic send_bit(input logic b);
        line = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Push the frame-level expectation, then drive start/data/[parity]/stop.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        ev_t ev;
        ev.data = d;
        if (!stop)                        ev.kind = K_FERR;
        else if (PARITY_ON && ((^d) ^ par)) ev.kind = K_PERR;
        else                              ev.kind = K_DONE;
        exp_q.push_back(ev);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PARITY_ON) send_bit(par);
        send_bit(stop);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes missing", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        checks    = 0;
        errors    = 0;
        n_done    = 0;
        last_byte = 8'h00;
        rst       = 1'b1;
        line      = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_byte", 32'(rx_byte), 32'h00);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // Clean frame 0xA5; parity bit chosen even so the parity build also accepts it.
        base = n_done;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_drain("a5_done");
        check("a5_byte", 32'(rx_byte), 32'hA5);
        check("a5_one_pulse", 32'(n_done - base), 32'd1);
        send_bit(1'b1);

        // Start glitch: 4 ticks low then high.
        line = 1'b0;
        repeat (16) @(negedge clk);
        line = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_active", 32'(active), 32'd0);
        check("glitch_byte", 32'(rx_byte), 32'hA5);

        // Framing error on 0x3C, then line held low.
        base = n_done;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_drain("3c_ferr");
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("stuck_low_active", 32'(active), 32'd0);
        check("ferr_byte", 32'(rx_byte), 32'hA5);
        check("ferr_no_done", 32'(n_done - base), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);

        // Back-to-back frames, second start right at the first stop end.
        base = n_done;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_drain("b2b_done");
        check("b2b_pulses", 32'(n_done - base), 32'd2);
        check("b2b_byte", 32'(rx_byte), 32'hFF);
        send_bit(1'b1);

        // Reset asserted midway through data bit 3 of 0x5A.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        line = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        last_byte = 8'h00;
        #1;
        check("async_rst_byte", 32'(rx_byte), 32'h00);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_ferr", 32'(ferr), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1);

        send_frame(8'h81, 1'b0, 1'b1);
        wait_drain("81_done");
        check("81_byte", 32'(rx_byte), 32'h81);
        send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        base = n_done;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain("par_ok");
        check("par_ok_byte", 32'(rx_byte), 32'h07);
        send_bit(1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_drain("par_bad");
        check("par_bad_done_count", 32'(n_done - base), 32'd1);
        send_bit(1'b1);
`endif

        repeat (8) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the UART transmitter in the TP2 UART path; it consumes the serial line the transmitter drives.
- Oversamples the line using the shared baud tick, which runs at 16x the bit rate.
- Recovers 8N1 frames, LSB first, and presents each received byte with a one-cycle done strobe plus a framing-error strobe.
- Sits between the pad/loopback line and the downstream byte consumer (interface/ALU control).

Parameters:
- Bits, 8, number of data bits per frame (supported range 5..8).
- SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit).
- OVS, 16, oversample ticks per bit; must be even, and OVS/2 is the mid-bit point.

Ports:
- i_Clock  input  1  system clock; all state changes on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_bd  input  1  baud oversample tick; 1-clock pulse at 16x the bit rate.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_Byte  output  8  last correctly received byte; bits above Bits read 0.
- o_Rx_Done  output  1  1-clock pulse when o_Rx_Byte has been updated.
- o_Frame_Err  output  1  1-clock pulse when the stop bit was sampled low.
- o_Rx_Active  output  1  high from start-bit detect until frame end.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - o_Rx_Byte=0, o_Rx_Done=0, o_Frame_Err=0, o_Rx_Active=0.
  - Tick counter, bit counter and shift register clear.
  - Both synchronizer flops and the previous-sample flop preset to 1.
- Input conditioning:
  - i_Rx_Serial passes through a 2-flop synchronizer; rx_s is the second flop.
  - A falling edge is rx_s=0 while its previous registered value is 1.
- IDLE:
  - Counters are held at 0.
  - A falling edge on rx_s moves to START and sets o_Rx_Active=1.
  - A line stuck low never re-triggers, because only a high-to-low edge arms the receiver.
- START:
  - The tick counter counts i_bd pulses.
  - On the tick that brings the count to OVS/2-1, rx_s is sampled.
  - If rx_s=0, clear the counter and go to DATA.
  - If rx_s=1, treat it as a glitch: go to IDLE with o_Rx_Active=0 and no strobes.
- DATA:
  - On each tick where the count equals OVS-1: shift rx_s into the MSB of the Bits-wide shift register (right shift), clear the counter and increment the bit counter.
  - After Bits samples, go to STOP.
- STOP:
  - On the tick where the count equals SB_TICK-1, sample rx_s.
  - If rx_s=1: o_Rx_Byte loads the shift register, o_Rx_Done=1 for exactly the next clock, and o_Frame_Err stays 0.
  - If rx_s=0: o_Frame_Err=1 for exactly the next clock and o_Rx_Byte is unchanged.
  - In both cases return to IDLE and clear o_Rx_Active.
- i_bd low: no counter advances in any state; the FSM holds.
- Invalid state encoding: recover to IDLE on the next clock.
- Latency: the strobe occurs 1 clock after the mid-stop-bit sampling tick. A new start edge is accepted the clock after the return to IDLE.
- Back-to-back frames: the start edge of the next frame may arrive during the final half of the stop bit. It is detected once in IDLE, because the edge detector compares against the registered previous sample.
- Strobes are never asserted together.
- Reset mid-frame aborts the frame with no strobe.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it lasts OVS ticks and is sampled at mid-bit.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - Adds output port o_Parity_Err (1 bit, reset 0).
  - On a mismatch with a good stop bit: o_Parity_Err pulses 1 clock, o_Rx_Done does not pulse, and o_Rx_Byte is unchanged.
  - A framing error takes priority; only o_Frame_Err pulses.
- Undefined: no PARITY state and no o_Parity_Err port.

Test Plan:
- Bench setup: i_bd pulses every 4 clocks. Drive 8N1 frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> o_Rx_Byte=0xA5, o_Rx_Done high exactly 1 clock, o_Frame_Err=0, o_Rx_Active falls with the strobe.
- Start glitch: line low for 4 ticks then high -> no strobe, FSM back in IDLE, o_Rx_Byte keeps its prior value.
- Frame 0x3C with stop bit forced 0 -> o_Frame_Err pulses 1 clock, o_Rx_Done stays 0, o_Rx_Byte still 0xA5. Line held low afterwards -> no new frame until high-then-low.
- Back-to-back frames 0x00 then 0xFF with the next start bit beginning exactly at the stop-bit end -> two o_Rx_Done pulses, bytes 0x00 then 0xFF.
- Assert i_reset during data bit 3 of 0x5A -> all outputs 0 immediately (asynchronously). A following clean frame 0x81 -> o_Rx_Byte=0x81.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> o_Rx_Done. 0x07 with parity 0 -> o_Parity_Err pulse, no o_Rx_Done.
